// File: rtl/layer_sequencer.sv
// layer_sequencer: gathers the parallel per-neuron results of one fully
// connected layer and replays them, in neuron order, as a serial stream
// for the next layer. Repeated strobes for a neuron already collected, and
// strobes that arrive while the frame is being streamed out, raise the
// sticky overflow flag.
//
// Handshake: a word transfers on a rising edge where o_valid and o_ready
// are both 1. While o_valid=1 and o_ready=0, o_data/o_idx/o_last hold
// their values. o_valid never drops without a transfer, except on reset.
module layer_sequencer #(
   parameter  int NN        = 10,
   parameter  int dataWidth = 16,
   localparam int IW        = (NN > 1) ? $clog2(NN) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NN-1:0]           i_valid,
   input  logic [NN*dataWidth-1:0] i_data,
   input  logic                    o_ready,
   output logic                    o_valid,
   output logic [dataWidth-1:0]    o_data,
   output logic [IW-1:0]           o_idx,
   output logic                    o_last,
   output logic                    busy,
   input  logic                    clr_ovf,
   output logic                    overflow,
   output logic [1:0]              state_dbg
);

   localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      SEND    = 2'd2
   } state_t;

   state_t                 state;
   logic [NN-1:0]          mask;
   logic [IW-1:0]          idx;
   logic [dataWidth-1:0]   mem [NN];

   logic [NN-1:0]          mask_next;
   logic                   all_done;
   logic                   at_last;
   logic [IW-1:0]          idx_inc;
   logic [dataWidth-1:0]   first_word;
   logic                   set_ovf;

   // Next-mask, completion, index-advance and error-detect decode.
   always_comb begin
      mask_next  = mask | i_valid;
      all_done   = &mask_next;
      at_last    = (idx == LAST_IDX);
      idx_inc    = at_last ? '0 : idx + IW'(1);
      // Word 0 may be arriving on the very edge that completes the frame.
      first_word = i_valid[0] ? i_data[dataWidth-1:0] : mem[0];
      set_ovf    = 1'b0;
      if (state == SEND) begin
         set_ovf = |i_valid;
      end else begin
         set_ovf = |(i_valid & mask);
      end
   end

   // Result buffer: captures strobed words outside SEND; frozen while streaming.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NN; k++) begin
         if ((state != SEND) && i_valid[k]) begin
            mem[k] <= i_data[k*dataWidth +: dataWidth];
         end
      end
   end

   // Frame FSM with registered stream outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         mask    <= '0;
         idx     <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_idx   <= '0;
         o_last  <= 1'b0;
      end else begin
         case (state)
            IDLE, COLLECT: begin
               mask <= mask_next;
               if (all_done) begin
                  state   <= SEND;
                  idx     <= '0;
                  o_valid <= 1'b1;
                  o_data  <= first_word;
                  o_idx   <= '0;
                  o_last  <= (LAST_IDX == '0);
               end else if (|mask_next) begin
                  state <= COLLECT;
               end
            end
            SEND: begin
               if (o_ready) begin
                  if (at_last) begin
                     state   <= IDLE;
                     mask    <= '0;
                     idx     <= '0;
                     o_valid <= 1'b0;
                     o_data  <= '0;
                     o_idx   <= '0;
                     o_last  <= 1'b0;
                  end else begin
                     idx    <= idx_inc;
                     o_idx  <= idx_inc;
                     o_data <= mem[idx_inc];
                     o_last <= (idx_inc == LAST_IDX);
                  end
               end
            end
            default: begin
               state <= IDLE;
               mask  <= '0;
               idx   <= '0;
            end
         endcase
      end
   end

   // Sticky overflow: a new error wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (set_ovf) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: a frame-level reference model for the NN=10
// instance checked every cycle, plus directed literal checks on NN=10,
// NN=5 and NN=1 instances.
module tb_layer_sequencer;

   localparam int NN = 10;
   localparam int DW = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- main instance (NN=10) ----------------
   logic [NN-1:0]    i_valid;
   logic [NN*DW-1:0] i_data;
   logic             o_ready, clr_ovf;
   logic             o_valid, o_last, busy, overflow;
   logic [DW-1:0]    o_data;
   logic [3:0]       o_idx;
   logic [1:0]       state_dbg;

   layer_sequencer #(.NN(NN), .dataWidth(DW)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
      .o_valid(o_valid), .o_data(o_data), .o_idx(o_idx), .o_last(o_last), .busy(busy),
      .clr_ovf(clr_ovf), .overflow(overflow), .state_dbg(state_dbg)
   );

   // ---------------- NN=5 instance ----------------
   logic [4:0]      i_valid5;
   logic [5*DW-1:0] i_data5;
   logic            o_ready5, clr_ovf5, o_valid5, o_last5, busy5, overflow5;
   logic [DW-1:0]   o_data5;
   logic [2:0]      o_idx5;
   logic [1:0]      state_dbg5;

   layer_sequencer #(.NN(5), .dataWidth(DW)) dut5 (
      .clk(clk), .rst(rst), .i_valid(i_valid5), .i_data(i_data5), .o_ready(o_ready5),
      .o_valid(o_valid5), .o_data(o_data5), .o_idx(o_idx5), .o_last(o_last5), .busy(busy5),
      .clr_ovf(clr_ovf5), .overflow(overflow5), .state_dbg(state_dbg5)
   );

   // ---------------- NN=1 instance ----------------
   logic [0:0]    i_valid1;
   logic [DW-1:0] i_data1;
   logic          o_ready1, clr_ovf1, o_valid1, o_last1, busy1, overflow1;
   logic [DW-1:0] o_data1;
   logic [0:0]    o_idx1;
   logic [1:0]    state_dbg1;

   layer_sequencer #(.NN(1), .dataWidth(DW)) dut1 (
      .clk(clk), .rst(rst), .i_valid(i_valid1), .i_data(i_data1), .o_ready(o_ready1),
      .o_valid(o_valid1), .o_data(o_data1), .o_idx(o_idx1), .o_last(o_last1), .busy(busy1),
      .clr_ovf(clr_ovf1), .overflow(overflow1), .state_dbg(state_dbg1)
   );

   // ---------------- check bookkeeping ----------------
   int checks = 0;
   int errors = 0;
   int hs_count = 0;
   logic [DW-1:0] got_q[$];
   logic [DW-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- reference model (NN=10) ----------------
   // A frame is "held" words plus a flag saying whether it is being replayed.
   logic          m_send, n_send;
   logic [NN-1:0] m_have, n_have;
   int            m_pos, n_pos;
   logic          m_ovf, n_ovf, n_hit;
   logic [DW-1:0] m_buf [NN];
   logic [DW-1:0] n_buf [NN];

   always_comb begin
      n_send = m_send;
      n_have = m_have;
      n_pos  = m_pos;
      n_ovf  = m_ovf;
      n_buf  = m_buf;
      n_hit  = 1'b0;
      if (m_send) begin
         if (i_valid != '0) n_hit = 1'b1;
         if (o_ready) begin
            if (m_pos == NN - 1) begin
               n_send = 1'b0;
               n_pos  = 0;
               n_have = '0;
            end else begin
               n_pos = m_pos + 1;
            end
         end
      end else begin
         for (int k = 0; k < NN; k++) begin
            if (i_valid[k]) begin
               if (m_have[k]) n_hit = 1'b1;
               n_buf[k]  = i_data[k*DW +: DW];
               n_have[k] = 1'b1;
            end
         end
         if (&n_have) n_send = 1'b1;
      end
      if (n_hit) n_ovf = 1'b1;
      else if (clr_ovf) n_ovf = 1'b0;
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_send <= 1'b0;
         m_have <= '0;
         m_pos  <= 0;
         m_ovf  <= 1'b0;
      end else begin
         m_send <= n_send;
         m_have <= n_have;
         m_pos  <= n_pos;
         m_ovf  <= n_ovf;
         m_buf  <= n_buf;
      end
   end

   // ---------------- per-cycle compare (falling edge) ----------------
   always @(negedge clk) begin
      check("o_valid", {31'd0, o_valid}, {31'd0, m_send});
      check("busy", {31'd0, busy}, {31'd0, (m_send || (m_have != '0))});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      if (m_send) begin
         check("o_data", {16'd0, o_data}, {16'd0, m_buf[m_pos]});
         check("o_idx", {28'd0, o_idx}, m_pos);
         check("o_last", {31'd0, o_last}, {31'd0, (m_pos == NN - 1)});
         if (o_ready) begin
            got_q.push_back(o_data);
            hs_count++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fill(input int base);
      for (int k = 0; k < NN; k++) i_data[k*DW +: DW] = DW'(base + k);
   endtask

   task automatic fill5(input int base);
      for (int k = 0; k < 5; k++) i_data5[k*DW +: DW] = DW'(base + k);
   endtask

   // Scoreboard: expected frame built from literals, compared to accepted words.
   task automatic check_frame(input string name, input int base, input int skip_k, input int skip_v);
      exp_q.delete();
      for (int k = 0; k < NN; k++) exp_q.push_back((k == skip_k) ? DW'(skip_v) : DW'(base + k));
      check({name, "_len"}, got_q.size(), NN);
      for (int k = 0; k < NN; k++) begin
         if (k < got_q.size()) check({name, "_word"}, {16'd0, got_q[k]}, {16'd0, exp_q[k]});
         else check({name, "_word"}, 32'hFFFF_FFFF, {16'd0, exp_q[k]});
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b0;
      i_valid = '0; i_data = '0; o_ready = 1'b1; clr_ovf = 1'b0;
      i_valid5 = '0; i_data5 = '0; o_ready5 = 1'b1; clr_ovf5 = 1'b0;
      i_valid1 = '0; i_data1 = '0; o_ready1 = 1'b0; clr_ovf1 = 1'b0;
      step(3);
      check("rst_o_valid", {31'd0, o_valid}, 32'd0);
      check("rst_o_data", {16'd0, o_data}, 32'd0);
      check("rst_o_idx", {28'd0, o_idx}, 32'd0);
      check("rst_o_last", {31'd0, o_last}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      rst = 1'b1;
      step(1);

      // Simultaneous results
      got_q.delete();
      fill(16'h0100);
      i_valid = '1;
      step(1);
      i_valid = '0;
      check("sim_first_valid", {31'd0, o_valid}, 32'd1);
      check("sim_first_idx", {28'd0, o_idx}, 32'd0);
      check("sim_first_data", {16'd0, o_data}, 32'h0100);
      step(12);
      check_frame("sim", 16'h0100, -1, 0);
      check("sim_end_busy", {31'd0, busy}, 32'd0);
      check("sim_end_ovf", {31'd0, overflow}, 32'd0);

      // Staggered results
      got_q.delete();
      fill(16'h0300);
      i_valid = 10'h01F;
      step(1);
      i_valid = '0;
      check("stag_busy_c1", {31'd0, busy}, 32'd1);
      check("stag_valid_c1", {31'd0, o_valid}, 32'd0);
      step(2);
      check("stag_valid_c3", {31'd0, o_valid}, 32'd0);
      i_valid = 10'h3E0;
      step(1);
      i_valid = '0;
      check("stag_valid_c4", {31'd0, o_valid}, 32'd1);
      step(12);
      check_frame("stag", 16'h0300, -1, 0);

      // Backpressure: ready pattern 1,0,0,1,0,0,...
      got_q.delete();
      hs_count = 0;
      fill(16'h0400);
      o_ready = 1'b0;
      i_valid = '1;
      step(1);
      i_valid = '0;
      for (int p = 0; p < 40; p++) begin
         o_ready = (p % 3 == 0);
         step(1);
      end
      o_ready = 1'b1;
      check("bp_handshakes", hs_count, 32'd10);
      check_frame("bp", 16'h0400, -1, 0);

      // Overflow: duplicate strobe in COLLECT
      got_q.delete();
      i_data[3*DW +: DW] = 16'h1111;
      i_valid = 10'h008;
      step(1);
      i_data[3*DW +: DW] = 16'h2222;
      step(1);
      i_valid = '0;
      check("ovf_dup", {31'd0, overflow}, 32'd1);
      for (int k = 0; k < NN; k++) if (k != 3) i_data[k*DW +: DW] = DW'(16'h0500 + k);
      i_valid = ~10'h008;
      step(1);
      i_valid = '0;
      step(12);
      check_frame("ovf_dup", 16'h0500, 3, 16'h2222);
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      check("ovf_clear", {31'd0, overflow}, 32'd0);

      // Overflow: strobes during SEND are dropped; set beats clear
      got_q.delete();
      o_ready = 1'b0;
      fill(16'h0600);
      i_valid = '1;
      step(1);
      fill(16'h7700);
      step(1);
      i_valid = '0;
      check("ovf_send", {31'd0, overflow}, 32'd1);
      clr_ovf = 1'b1;
      i_valid = '1;
      step(1);
      i_valid = '0;
      check("ovf_set_wins", {31'd0, overflow}, 32'd1);
      step(1);
      clr_ovf = 1'b0;
      check("ovf_clear2", {31'd0, overflow}, 32'd0);
      o_ready = 1'b1;
      step(12);
      check_frame("ovf_send", 16'h0600, -1, 0);

      // Reset in the middle of SEND
      fill(16'h0800);
      i_valid = '1;
      step(1);
      i_valid = '0;
      step(4);
      check("mid_idx4", {28'd0, o_idx}, 32'd4);
      rst = 1'b0;
      #1;
      check("mid_async_valid", {31'd0, o_valid}, 32'd0);
      check("mid_async_busy", {31'd0, busy}, 32'd0);
      step(2);
      rst = 1'b1;
      step(2);
      check("mid_after_valid", {31'd0, o_valid}, 32'd0);
      check("mid_after_busy", {31'd0, busy}, 32'd0);
      got_q.delete();
      fill(16'h0900);
      i_valid = '1;
      step(1);
      i_valid = '0;
      step(12);
      check_frame("mid_fresh", 16'h0900, -1, 0);

      // New frame coincident with the final handshake is dropped
      got_q.delete();
      fill(16'h0A00);
      i_valid = '1;
      step(1);
      i_valid = '0;
      step(9);
      check("b2b_last", {31'd0, o_last}, 32'd1);
      fill(16'h0B00);
      i_valid = '1;
      step(1);
      i_valid = '0;
      check("b2b_busy", {31'd0, busy}, 32'd0);
      check("b2b_ovf", {31'd0, overflow}, 32'd1);
      step(2);
      check("b2b_busy_later", {31'd0, busy}, 32'd0);
      check_frame("b2b", 16'h0A00, -1, 0);
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;

      // NN=5
      fill5(16'h0C00);
      i_valid5 = '1;
      step(1);
      i_valid5 = '0;
      for (int k = 0; k < 4; k++) begin
         check("n5_valid", {31'd0, o_valid5}, 32'd1);
         check("n5_idx", {29'd0, o_idx5}, k);
         check("n5_last", {31'd0, o_last5}, 32'd0);
         check("n5_data", {16'd0, o_data5}, 32'h0C00 + k);
         step(1);
      end
      check("n5_idx_last", {29'd0, o_idx5}, 32'd4);
      check("n5_last_last", {31'd0, o_last5}, 32'd1);
      check("n5_data_last", {16'd0, o_data5}, 32'h0C04);
      fill5(16'h0D00);
      i_valid5 = '1;
      step(1);
      i_valid5 = '0;
      check("n5_end_valid", {31'd0, o_valid5}, 32'd0);
      check("n5_end_busy", {31'd0, busy5}, 32'd0);
      check("n5_end_ovf", {31'd0, overflow5}, 32'd1);

      // NN=1
      i_data1 = 16'h0E01;
      i_valid1 = 1'b1;
      step(1);
      i_valid1 = 1'b0;
      check("n1_valid", {31'd0, o_valid1}, 32'd1);
      check("n1_last", {31'd0, o_last1}, 32'd1);
      check("n1_idx", {31'd0, o_idx1}, 32'd0);
      check("n1_data", {16'd0, o_data1}, 32'h0E01);
      step(2);
      check("n1_hold", {16'd0, o_data1}, 32'h0E01);
      o_ready1 = 1'b1;
      i_data1 = 16'h0E02;
      i_valid1 = 1'b1;
      step(1);
      i_valid1 = 1'b0;
      check("n1_drop_valid", {31'd0, o_valid1}, 32'd0);
      check("n1_drop_busy", {31'd0, busy1}, 32'd0);
      check("n1_drop_ovf", {31'd0, overflow1}, 32'd1);
      i_data1 = 16'h0E03;
      i_valid1 = 1'b1;
      step(1);
      i_valid1 = 1'b0;
      check("n1_next_data", {16'd0, o_data1}, 32'h0E03);
      check("n1_next_last", {31'd0, o_last1}, 32'd1);
      step(1);
      check("n1_done_valid", {31'd0, o_valid1}, 32'd0);

      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
